mem_access_unit: RTL and testbench

- Parametrised load/store unit between the multi-cycle core and the memory bus.
- Replaces the fixed 3-bit option sideband with:
  - lane-decoded byte strobes;
  - sign/zero extension of load data;
  - misalignment and illegal-size detection;
  - a valid/ack wait-state handshake.
- Supports 32- or 64-bit data paths, so the same unit serves RV32 and RV64 cores.

---
 rtl/mem_access_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a multi-cycle core and a
// valid/ack memory bus. It decodes byte strobes, replicates store data
// across lanes, and sign- or zero-extends load data. It also flags
// misaligned and illegal requests without touching the bus.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a bus request
// that is not acked within TIMEOUT_CYCLES BUS cycles fails with cause 11.
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_valid,
  input  logic                    core_write,
  input  logic [2:0]              core_option,
  input  logic [ADDR_WIDTH-1:0]   core_address,
  input  logic [DATA_WIDTH-1:0]   core_write_data,
  output logic                    core_ready,
  output logic [DATA_WIDTH-1:0]   core_read_data,
  output logic                    core_error,
  output logic [1:0]              core_error_cause,
  output logic                    busy,
  output logic                    bus_read,
  output logic                    bus_write,
  output logic [ADDR_WIDTH-1:0]   bus_address,
  output logic [DATA_WIDTH-1:0]   bus_write_data,
  output logic [DATA_WIDTH/8-1:0] bus_strobe,
  input  logic [DATA_WIDTH-1:0]   bus_read_data,
  input  logic                    bus_ack
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [2:0] OPT_B  = 3'b000;
  localparam logic [2:0] OPT_H  = 3'b001;
  localparam logic [2:0] OPT_W  = 3'b010;
  localparam logic [2:0] OPT_D  = 3'b011;
  localparam logic [2:0] OPT_BU = 3'b100;
  localparam logic [2:0] OPT_HU = 3'b101;
  localparam logic [2:0] OPT_WU = 3'b110;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // Reject unsupported configurations at elaboration time.
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("mem_access_unit: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [1:0]            state_reg, state_next;
  logic [1:0]            cause_reg, cause_next;
  logic                  write_reg;
  logic [2:0]            option_reg;
  logic [ADDR_WIDTH-1:0] address_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic                  req_illegal;
  logic                  req_misaligned;
  logic                  timer_expired;

  logic [LANE_W-1:0]     lane;
  logic [LANE_W+2:0]     lane_shift;
  logic [31:0]           lane_word;
  logic [STRB_W-1:0]     strobe_base;
  logic [STRB_W-1:0]     strobe_lanes;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  bus_active;

  // Classify the incoming request; an illegal option outranks misalignment.
  always_comb begin
    req_illegal = 1'b0;
    if (core_option == 3'b111) begin
      req_illegal = 1'b1;
    end
    if (DATA_WIDTH == 32 && (core_option == OPT_D || core_option == OPT_WU)) begin
      req_illegal = 1'b1;
    end
    if (core_write && core_option[2]) begin
      req_illegal = 1'b1;
    end
    req_misaligned = 1'b0;
    case (core_option[1:0])
      2'b01:   req_misaligned = core_address[0];
      2'b10:   req_misaligned = |core_address[1:0];
      2'b11:   req_misaligned = |core_address[LANE_W-1:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  // Next-state and error-cause selection.
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    case (state_reg)
      IDLE: begin
        cause_next = CAUSE_NONE;
        if (core_valid) begin
          if (req_illegal) begin
            state_next = ERR;
            cause_next = CAUSE_ILLEGAL;
          end else if (req_misaligned) begin
            state_next = ERR;
            cause_next = CAUSE_MISALIGN;
          end else begin
            state_next = BUS;
          end
        end
      end
      BUS: begin
        // An ack arriving in the same cycle as expiry still completes normally.
        if (bus_ack) begin
          state_next = RESP;
        end else if (timer_expired) begin
          state_next = ERR;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state and latched cause registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cause_reg <= CAUSE_NONE;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
    end
  end

  // Capture the request fields once, when it is accepted in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_reg   <= 1'b0;
      option_reg  <= 3'b000;
      address_reg <= '0;
      wdata_reg   <= '0;
    end else if (state_reg == IDLE && core_valid) begin
      write_reg   <= core_write;
      option_reg  <= core_option;
      address_reg <= core_address;
      wdata_reg   <= core_write_data;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timer_reg;

  // Count unacked BUS cycles; the counter sits at zero outside BUS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_reg <= 16'd0;
    end else if (state_reg != BUS) begin
      timer_reg <= 16'd0;
    end else if (!bus_ack) begin
      timer_reg <= timer_reg + 16'd1;
    end
  end

  assign timer_expired = (timer_reg == TIMEOUT_LAST);
`else
  assign timer_expired = 1'b0;
`endif

  // Lane selection and byte-lane strobe pattern for the latched request.
  assign lane       = address_reg[LANE_W-1:0];
  assign lane_shift = {lane, 3'b000};
  assign lane_word  = 32'(bus_read_data >> lane_shift);

  always_comb begin
    case (option_reg[1:0])
      2'b00:   strobe_base = STRB_W'(4'h1);
      2'b01:   strobe_base = STRB_W'(4'h3);
      2'b10:   strobe_base = STRB_W'(4'hF);
      default: strobe_base = '1;
    endcase
    strobe_lanes = strobe_base << lane;
  end

  // Store data: narrow stores are replicated so every lane carries the value.
  always_comb begin
    case (option_reg[1:0])
      2'b00:   store_data = {(DATA_WIDTH/8){wdata_reg[7:0]}};
      2'b01:   store_data = {(DATA_WIDTH/16){wdata_reg[15:0]}};
      2'b10:   store_data = {(DATA_WIDTH/32){wdata_reg[31:0]}};
      default: store_data = wdata_reg;
    endcase
  end

  // Load data: pick the addressed lane and extend it to the full width.
  always_comb begin
    load_ext = bus_read_data;
    case (option_reg)
      OPT_B:   load_ext = DATA_WIDTH'($signed(lane_word[7:0]));
      OPT_H:   load_ext = DATA_WIDTH'($signed(lane_word[15:0]));
      OPT_W:   load_ext = DATA_WIDTH'($signed(lane_word[31:0]));
      OPT_BU:  load_ext = DATA_WIDTH'(lane_word[7:0]);
      OPT_HU:  load_ext = DATA_WIDTH'(lane_word[15:0]);
      OPT_WU:  load_ext = DATA_WIDTH'(lane_word[31:0]);
      default: load_ext = bus_read_data;
    endcase
  end

  // The load result holds until the next completion; a failure clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_reg <= '0;
    end else if (state_next == ERR) begin
      rdata_reg <= '0;
    end else if (state_reg == BUS && bus_ack && !write_reg) begin
      rdata_reg <= load_ext;
    end
  end

  assign bus_active       = (state_reg == BUS);
  assign busy             = (state_reg != IDLE);
  assign bus_read         = bus_active & ~write_reg;
  assign bus_write        = bus_active & write_reg;
  assign bus_address      = bus_active ? {address_reg[ADDR_WIDTH-1:LANE_W], LANE_W'(0)} : '0;
  assign bus_strobe       = bus_write ? strobe_lanes : '0;
  assign bus_write_data   = bus_write ? store_data : '0;
  assign core_ready       = (state_reg == RESP) || (state_reg == ERR);
  assign core_error       = (state_reg == ERR);
  assign core_error_cause = (state_reg == ERR) ? cause_reg : CAUSE_NONE;
  assign core_read_data   = rdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a 32-bit and a 64-bit instance, table-driven
// vectors checked through a scoreboard queue, plus hand-written sequences
// for ack-while-idle, timeout (when MEM_TIMEOUT_EN is defined) and mid-bus reset.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        c_write;
  logic [2:0]  c_option;
  logic [31:0] c_address;
  logic [63:0] c_wdata;
  logic [63:0] b_rdata;
  logic        valid32, valid64, ack32, ack64;
  logic        sel64;

  logic        rdy32, err32, busy32, br32, bw32;
  logic [1:0]  cause32;
  logic [31:0] rd32, ba32, bwd32;
  logic [3:0]  st32;

  logic        rdy64, err64, busy64, br64, bw64;
  logic [1:0]  cause64;
  logic [63:0] rd64, bwd64;
  logic [31:0] ba64;
  logic [7:0]  st64;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_dut32 (
    .clk(clk), .reset(reset),
    .core_valid(valid32), .core_write(c_write), .core_option(c_option),
    .core_address(c_address), .core_write_data(c_wdata[31:0]),
    .core_ready(rdy32), .core_read_data(rd32), .core_error(err32),
    .core_error_cause(cause32), .busy(busy32),
    .bus_read(br32), .bus_write(bw32), .bus_address(ba32),
    .bus_write_data(bwd32), .bus_strobe(st32),
    .bus_read_data(b_rdata[31:0]), .bus_ack(ack32)
  );

  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_dut64 (
    .clk(clk), .reset(reset),
    .core_valid(valid64), .core_write(c_write), .core_option(c_option),
    .core_address(c_address), .core_write_data(c_wdata),
    .core_ready(rdy64), .core_read_data(rd64), .core_error(err64),
    .core_error_cause(cause64), .busy(busy64),
    .bus_read(br64), .bus_write(bw64), .bus_address(ba64),
    .bus_write_data(bwd64), .bus_strobe(st64),
    .bus_read_data(b_rdata), .bus_ack(ack64)
  );

  // Selected-instance view of the outputs.
  logic        m_rdy, m_err, m_busy, m_br, m_bw;
  logic [1:0]  m_cause;
  logic [63:0] m_rd, m_bwd;
  logic [31:0] m_ba;
  logic [7:0]  m_st;

  always_comb begin
    if (sel64) begin
      m_rdy = rdy64; m_err = err64; m_busy = busy64; m_br = br64; m_bw = bw64;
      m_cause = cause64; m_rd = rd64; m_bwd = bwd64; m_ba = ba64; m_st = st64;
    end else begin
      m_rdy = rdy32; m_err = err32; m_busy = busy32; m_br = br32; m_bw = bw32;
      m_cause = cause32; m_rd = {32'd0, rd32}; m_bwd = {32'd0, bwd32};
      m_ba = ba32; m_st = {4'd0, st32};
    end
  end

  typedef struct {
    logic        wide;
    logic        write;
    logic [2:0]  opt;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          delay;
    logic        poke;
    logic        exp_err;
    logic [1:0]  exp_cause;
    logic [31:0] exp_baddr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_bwdata;
    logic        chk_rd;
    logic [63:0] exp_rd;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs[NVEC];
  vec_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_valid(input logic b);
    if (sel64) valid64 = b; else valid32 = b;
  endtask

  task automatic drive_ack(input logic b);
    if (sel64) ack64 = b; else ack32 = b;
  endtask

  function automatic vec_t mkv(
    input logic wide, input logic write, input logic [2:0] opt, input logic [31:0] addr,
    input logic [63:0] wdata, input logic [63:0] rdata, input int delay, input logic poke,
    input logic exp_err, input logic [1:0] exp_cause, input logic [31:0] exp_baddr,
    input logic [7:0] exp_strb, input logic [63:0] exp_bwdata, input logic chk_rd,
    input logic [63:0] exp_rd);
    vec_t v;
    v.wide = wide; v.write = write; v.opt = opt; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.delay = delay; v.poke = poke; v.exp_err = exp_err;
    v.exp_cause = exp_cause; v.exp_baddr = exp_baddr; v.exp_strb = exp_strb;
    v.exp_bwdata = exp_bwdata; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  // Issue one request, answer the bus after v.delay wait cycles, and check the
  // completion against the scoreboard entry.
  task automatic run_txn(input int idx, input vec_t v);
    vec_t e;
    int   cyc;
    int   waited;
    bit   done;
    bit   saw_bus;
    sel64 = v.wide;
    @(negedge clk);
    c_write = v.write; c_option = v.opt; c_address = v.addr;
    c_wdata = v.wdata; b_rdata = v.rdata;
    drive_valid(1'b1);
    sb_q.push_back(v);
    @(negedge clk);
    drive_valid(1'b0);
    cyc = 1; waited = 0; done = 0; saw_bus = 0;
    while (!done && cyc <= 30) begin
      if (m_br || m_bw) begin
        saw_bus = 1;
        check("bus_dir", {62'd0, m_br, m_bw}, {62'd0, !v.write, v.write});
        check("bus_address", 64'(m_ba), 64'(v.exp_baddr));
        check("bus_strobe", 64'(m_st), 64'(v.exp_strb));
        if (v.write) check("bus_write_data", m_bwd, v.exp_bwdata);
        check("busy_in_bus", 64'(m_busy), 64'd1);
        if (v.poke && waited == 1) begin
          c_write = 1'b1; c_option = 3'b000; c_address = 32'h40;
          drive_valid(1'b1);
        end
        if (waited == v.delay) drive_ack(1'b1);
        else waited++;
      end
      if (m_rdy) begin
        e = sb_q.pop_front();
        check("latency", 64'(cyc), e.exp_err ? 64'd1 : 64'(2 + e.delay));
        check("core_error", 64'(m_err), 64'(e.exp_err));
        check("error_cause", 64'(m_cause), 64'(e.exp_cause));
        check("bus_used", 64'(saw_bus), 64'(!e.exp_err));
        if (e.chk_rd) check("core_read_data", m_rd, e.exp_rd);
        $display("txn %0d wide=%0d write=%0d opt=%b addr=%h -> err=%0d cause=%0d rdata=%h cycles=%0d",
                 idx, e.wide, e.write, e.opt, e.addr, m_err, m_cause, m_rd, cyc);
        done = 1;
      end
      @(negedge clk);
      drive_ack(1'b0);
      drive_valid(1'b0);
      cyc++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL txn_%0d_no_ready actual=none required=core_ready", idx);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    check("ready_one_cycle", 64'(m_rdy), 64'd0);
    check("idle_after", 64'(m_busy), 64'd0);
  endtask

  initial begin
    int n;
    int k;
    reset = 1'b1; sel64 = 1'b0;
    valid32 = 0; valid64 = 0; ack32 = 0; ack64 = 0;
    c_write = 0; c_option = 3'b000; c_address = '0; c_wdata = '0; b_rdata = '0;

    //         wide write opt     addr          wdata                   rdata                  dly poke err cause  baddr         strb   bwdata                  chk rd
    vecs[0]  = mkv(0, 0, 3'b010, 32'h0000_0104, 64'h0, 64'hDEAD_BEEF,           0, 0, 0, 2'b00, 32'h104, 8'h00, 64'h0,                  1, 64'hDEAD_BEEF);
    vecs[1]  = mkv(0, 0, 3'b000, 32'h0000_0103, 64'h0, 64'h8000_0000,           0, 0, 0, 2'b00, 32'h100, 8'h00, 64'h0,                  1, 64'hFFFF_FF80);
    vecs[2]  = mkv(0, 0, 3'b100, 32'h0000_0103, 64'h0, 64'h8000_0000,           1, 0, 0, 2'b00, 32'h100, 8'h00, 64'h0,                  1, 64'h0000_0080);
    vecs[3]  = mkv(0, 1, 3'b001, 32'h0000_0202, 64'h1234_ABCD, 64'h0,           0, 0, 0, 2'b00, 32'h200, 8'h0C, 64'hABCD_ABCD,          0, 64'h0);
    vecs[4]  = mkv(0, 0, 3'b010, 32'h0000_0102, 64'h0, 64'h0,                   0, 0, 1, 2'b01, 32'h0,   8'h00, 64'h0,                  1, 64'h0);
    vecs[5]  = mkv(0, 0, 3'b011, 32'h0000_0100, 64'h0, 64'h0,                   0, 0, 1, 2'b10, 32'h0,   8'h00, 64'h0,                  1, 64'h0);
    vecs[6]  = mkv(0, 0, 3'b111, 32'h0000_0100, 64'h0, 64'h0,                   0, 0, 1, 2'b10, 32'h0,   8'h00, 64'h0,                  1, 64'h0);
    vecs[7]  = mkv(0, 1, 3'b100, 32'h0000_0100, 64'h0, 64'h0,                   0, 0, 1, 2'b10, 32'h0,   8'h00, 64'h0,                  1, 64'h0);
    vecs[8]  = mkv(0, 0, 3'b001, 32'h0000_0102, 64'h0, 64'h8765_4321,           2, 0, 0, 2'b00, 32'h100, 8'h00, 64'h0,                  1, 64'hFFFF_8765);
    vecs[9]  = mkv(0, 0, 3'b101, 32'h0000_0102, 64'h0, 64'h8765_4321,           0, 0, 0, 2'b00, 32'h100, 8'h00, 64'h0,                  1, 64'h0000_8765);
    vecs[10] = mkv(0, 1, 3'b000, 32'h0000_0101, 64'h55, 64'h0,                  1, 0, 0, 2'b00, 32'h100, 8'h02, 64'h5555_5555,          0, 64'h0);
    vecs[11] = mkv(0, 1, 3'b010, 32'h0000_0010, 64'hCAFE_F00D, 64'h0,           0, 0, 0, 2'b00, 32'h010, 8'h0F, 64'hCAFE_F00D,          0, 64'h0);
    vecs[12] = mkv(0, 0, 3'b001, 32'h0000_0001, 64'h0, 64'h0,                   0, 0, 1, 2'b01, 32'h0,   8'h00, 64'h0,                  1, 64'h0);
    vecs[13] = mkv(0, 0, 3'b110, 32'h0000_0100, 64'h0, 64'h0,                   0, 0, 1, 2'b10, 32'h0,   8'h00, 64'h0,                  1, 64'h0);
    vecs[14] = mkv(0, 0, 3'b011, 32'h0000_0101, 64'h0, 64'h0,                   0, 0, 1, 2'b10, 32'h0,   8'h00, 64'h0,                  1, 64'h0);
    vecs[15] = mkv(0, 0, 3'b010, 32'h0000_0108, 64'h0, 64'h7FFF_0000,           0, 0, 0, 2'b00, 32'h108, 8'h00, 64'h0,                  1, 64'h7FFF_0000);
    vecs[16] = mkv(1, 0, 3'b011, 32'h0000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 1, 0, 2'b00, 32'h008, 8'h00, 64'h0,                  1, 64'h0123_4567_89AB_CDEF);
    vecs[17] = mkv(1, 1, 3'b000, 32'h0000_0015, 64'hA5, 64'h0,                  0, 0, 0, 2'b00, 32'h010, 8'h20, 64'hA5A5_A5A5_A5A5_A5A5, 0, 64'h0);
    vecs[18] = mkv(1, 0, 3'b010, 32'h0000_0004, 64'h0, 64'h8000_0000_1234_5678, 1, 0, 0, 2'b00, 32'h000, 8'h00, 64'h0,                  1, 64'hFFFF_FFFF_8000_0000);
    vecs[19] = mkv(1, 0, 3'b110, 32'h0000_0004, 64'h0, 64'h8000_0000_1234_5678, 0, 0, 0, 2'b00, 32'h000, 8'h00, 64'h0,                  1, 64'h0000_0000_8000_0000);
    vecs[20] = mkv(1, 0, 3'b011, 32'h0000_0004, 64'h0, 64'h0,                   0, 0, 1, 2'b01, 32'h0,   8'h00, 64'h0,                  1, 64'h0);
    vecs[21] = mkv(1, 1, 3'b010, 32'h0000_0024, 64'h1122_3344, 64'h0,           2, 0, 0, 2'b00, 32'h020, 8'hF0, 64'h1122_3344_1122_3344, 0, 64'h0);
    vecs[22] = mkv(1, 1, 3'b011, 32'h0000_0018, 64'h0102_0304_0506_0708, 64'h0, 0, 0, 0, 2'b00, 32'h018, 8'hFF, 64'h0102_0304_0506_0708, 0, 64'h0);
    vecs[23] = mkv(1, 1, 3'b110, 32'h0000_0100, 64'h0, 64'h0,                   0, 0, 1, 2'b10, 32'h0,   8'h00, 64'h0,                  1, 64'h0);

    // Asynchronous reset before the first clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_ready", 64'(rdy32), 64'd0);
    check("rst_bus", {62'd0, br32, bw32}, 64'd0);
    check("rst_rdata", 64'(rd32), 64'd0);
    check("rst_busy64", 64'(busy64), 64'd0);
    check("rst_strobe64", 64'(st64), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_txn(i, vecs[i]);
    end

    // Ack while idle must be ignored; the last 32-bit load result holds.
    sel64 = 1'b0;
    @(negedge clk);
    ack32 = 1'b1;
    @(negedge clk);
    ack32 = 1'b0;
    check("idle_ack_busy", 64'(busy32), 64'd0);
    check("idle_ack_ready", 64'(rdy32), 64'd0);
    check("rdata_hold", 64'(rd32), 64'h7FFF_0000);
    $display("txn idle_ack -> busy=%0d ready=%0d rdata=%h", busy32, rdy32, rd32);

`ifdef MEM_TIMEOUT_EN
    // No ack: the request drops after TIMEOUT_CYCLES bus cycles with cause 11.
    @(negedge clk);
    c_write = 1'b0; c_option = 3'b010; c_address = 32'h100; valid32 = 1'b1;
    @(negedge clk);
    valid32 = 1'b0;
    n = 0; k = 0;
    while (!rdy32 && k < 20) begin
      if (br32) n++;
      @(negedge clk);
      k++;
    end
    check("to_ready", 64'(rdy32), 64'd1);
    check("to_error", 64'(err32), 64'd1);
    check("to_cause", 64'(cause32), 64'd3);
    check("to_bus_cycles", 64'(n), 64'd4);
    check("to_bus_dropped", 64'(br32), 64'd0);
    $display("txn timeout -> bus_cycles=%0d err=%0d cause=%0d", n, err32, cause32);
    @(negedge clk);
`endif

    // Reset in the middle of a bus wait drops the request immediately.
    @(negedge clk);
    c_write = 1'b0; c_option = 3'b010; c_address = 32'h100; valid32 = 1'b1;
    @(negedge clk);
    valid32 = 1'b0;
    check("pre_rst_read", 64'(br32), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_read", 64'(br32), 64'd0);
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_ready", 64'(rdy32), 64'd0);
    $display("txn mid_bus_reset -> bus_read=%0d busy=%0d ready=%0d", br32, busy32, rdy32);
    @(negedge clk);
    reset = 1'b1;
    ack32 = 1'b1;
    @(negedge clk);
    ack32 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("post_rst_ready", 64'(rdy32), 64'd0);
      check("post_rst_busy", 64'(busy32), 64'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
